// File: rtl/dtc_trig_decode_gen2.sv
// Serial DTC trigger decoder: turns L0/L1 codes on dtc_trig into active-low strobes,
// gating L1 on an L0-to-L1 latency window and keeping wrap-around statistics.
module dtc_trig_decode_gen2 #(
  parameter int SHIFT    = 4,
  parameter int L0_WIDTH = 10,
  parameter int L1_WIDTH = 2,
  parameter int HOLDOFF  = 6,
  parameter int WIN_MIN  = 0,
  parameter int WIN_MAX  = 200,
  parameter int AGE_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             dtc_trig,
  input  logic             en_l0,
  input  logic             en_l1,
  input  logic             win_check,
  input  logic             cnt_clr,
  output logic             trig_l0n,
  output logic             trig_l1n,
  output logic             busy,
  output logic             l1_err,
  output logic [CNT_W-1:0] l0_cnt,
  output logic [CNT_W-1:0] l1_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, L0_PULSE, CMD_WAIT, L1_PULSE, HOLD} state_t;

  localparam int PC_MAX_A = (L0_WIDTH > L1_WIDTH) ? L0_WIDTH : L1_WIDTH;
  localparam int PC_MAX   = (PC_MAX_A > HOLDOFF) ? PC_MAX_A : HOLDOFF;
  localparam int PC_W     = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;
  localparam logic [3:0] CODE_L0  = 4'b0010;
  localparam logic [3:0] CODE_CMD = 4'b0011;
  localparam logic [3:0] CODE_L1  = 4'b0110;
  localparam logic [AGE_W-1:0] WMAX = AGE_W'(WIN_MAX);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SHIFT-1:0] sr_q, sr_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             armed_q, armed_d;
  logic             l0n_q, l0n_d, l1n_q, l1n_d, busy_q, busy_d, err_q, err_d;
  logic [CNT_W-1:0] l0_cnt_q, l0_cnt_d, l1_cnt_q, l1_cnt_d, err_cnt_q, err_cnt_d;
  logic             l0_inc_s, l1_inc_s, err_inc_s, win_lo_ok_s, ok_s;
  logic [3:0]       code_s;

  // A zero lower bound needs no compare on the unsigned age.
  generate
    if (WIN_MIN == 0) begin : g_no_min
      assign win_lo_ok_s = 1'b1;
    end else begin : g_min
      assign win_lo_ok_s = (age_q >= AGE_W'(WIN_MIN));
    end
  endgenerate

  assign code_s = sr_q[3:0];
  assign ok_s   = en_l1 & (~win_check | (armed_q & win_lo_ok_s & (age_q <= WMAX)));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q + PC_W'(1);
    l0n_d     = 1'b1;
    l1n_d     = 1'b1;
    err_d     = 1'b0;
    l0_inc_s  = 1'b0;
    l1_inc_s  = 1'b0;
    err_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (code_s == CODE_L0 && en_l0) begin
          state_d  = L0_PULSE;
          l0n_d    = 1'b0;
          l0_inc_s = 1'b1;
        end else if (code_s == CODE_CMD) begin
          state_d = CMD_WAIT;
        end
      end
      L0_PULSE: begin
        if (pc_q == PC_W'(L0_WIDTH - 1)) begin
          state_d = IDLE;
          pc_d    = '0;
        end else begin
          l0n_d = 1'b0;
        end
      end
      CMD_WAIT: begin
        pc_d    = '0;
        state_d = HOLD;
        if (code_s == CODE_L1 && ok_s) begin
          state_d  = L1_PULSE;
          l1n_d    = 1'b0;
          l1_inc_s = 1'b1;
        end else if (code_s == CODE_L1 && en_l1) begin
          err_d     = 1'b1;
          err_inc_s = 1'b1;
        end
      end
      L1_PULSE: begin
        if (pc_q == PC_W'(L1_WIDTH - 1)) begin
          state_d = IDLE;
          pc_d    = '0;
        end else begin
          l1n_d = 1'b0;
        end
      end
      HOLD: begin
        if (pc_q == PC_W'(HOLDOFF - 1)) begin
          state_d = IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    busy_d = (state_d != IDLE);

    // Age restarts on every accepted L0 and saturates; an accepted L1 consumes the arm.
    if (l0_inc_s) begin
      age_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      age_d   = (age_q == {AGE_W{1'b1}}) ? age_q : age_q + AGE_W'(1);
      armed_d = ~l1_inc_s & ~(age_q > WMAX);
    end else begin
      age_d   = age_q;
      armed_d = 1'b0;
    end

    sr_d      = {sr_q[SHIFT-2:0], dtc_trig};
    l0_cnt_d  = cnt_clr ? '0 : l0_cnt_q  + {{(CNT_W-1){1'b0}}, l0_inc_s};
    l1_cnt_d  = cnt_clr ? '0 : l1_cnt_q  + {{(CNT_W-1){1'b0}}, l1_inc_s};
    err_cnt_d = cnt_clr ? '0 : err_cnt_q + {{(CNT_W-1){1'b0}}, err_inc_s};
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      sr_q      <= '0;
      age_q     <= '0;
      armed_q   <= 1'b0;
      l0n_q     <= 1'b1;
      l1n_q     <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      l0_cnt_q  <= '0;
      l1_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sr_q      <= sr_d;
      age_q     <= age_d;
      armed_q   <= armed_d;
      l0n_q     <= l0n_d;
      l1n_q     <= l1n_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      l0_cnt_q  <= l0_cnt_d;
      l1_cnt_q  <= l1_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign trig_l0n = l0n_q;
  assign trig_l1n = l1n_q;
  assign busy     = busy_q;
  assign l1_err   = err_q;
  assign l0_cnt   = l0_cnt_q;
  assign l1_cnt   = l1_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dtc_trig_decode_gen2.sv
// Directed bench for dtc_trig_decode_gen2; a second narrow-counter instance covers wrap-around.
module tb_dtc_trig_decode_gen2;
  logic clkin = 1'b0;
  logic reset, dtc_trig, dtc_trig_w, en_l0, en_l1, win_check, cnt_clr;
  logic trig_l0n, trig_l1n, busy, l1_err;
  logic [15:0] l0_cnt, l1_cnt, err_cnt;
  logic w_l0n, w_l1n, w_busy, w_err;
  logic [3:0] w_l0_cnt, w_l1_cnt, w_err_cnt;
  int tests = 0;
  int fails = 0;

  always #5 clkin = ~clkin;

  dtc_trig_decode_gen2 dut (
    .clkin(clkin), .reset(reset), .dtc_trig(dtc_trig), .en_l0(en_l0), .en_l1(en_l1),
    .win_check(win_check), .cnt_clr(cnt_clr), .trig_l0n(trig_l0n), .trig_l1n(trig_l1n),
    .busy(busy), .l1_err(l1_err), .l0_cnt(l0_cnt), .l1_cnt(l1_cnt), .err_cnt(err_cnt)
  );

  dtc_trig_decode_gen2 #(.L0_WIDTH(1), .CNT_W(4)) dut_w (
    .clkin(clkin), .reset(reset), .dtc_trig(dtc_trig_w), .en_l0(en_l0), .en_l1(en_l1),
    .win_check(win_check), .cnt_clr(cnt_clr), .trig_l0n(w_l0n), .trig_l1n(w_l1n),
    .busy(w_busy), .l1_err(w_err), .l0_cnt(w_l0_cnt), .l1_cnt(w_l1_cnt), .err_cnt(w_err_cnt)
  );

  task automatic drive_bit(input logic b);
    @(negedge clkin);
    dtc_trig = b;
  endtask

  task automatic drive_code(input logic [3:0] code);
    for (int i = 3; i >= 0; i--) drive_bit(code[i]);
  endtask

  task automatic drive_l1(input logic last);
    drive_code(4'b0011);
    drive_bit(last);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clkin);
  endtask

  // Samples n negedges; index 1 is the first negedge after the last driven bit.
  task automatic measure(input int n, output int l0_low, output int l0_first, output int l1_low,
                         output int l1_first, output int err_hi, output int err_first,
                         output int busy_hi);
    l0_low = 0; l0_first = -1; l1_low = 0; l1_first = -1;
    err_hi = 0; err_first = -1; busy_hi = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clkin);
      if (trig_l0n === 1'b0) begin l0_low++; if (l0_first < 0) l0_first = i; end
      if (trig_l1n === 1'b0) begin l1_low++; if (l1_first < 0) l1_first = i; end
      if (l1_err === 1'b1) begin err_hi++; if (err_first < 0) err_first = i; end
      if (busy === 1'b1) busy_hi++;
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({trig_l0n, trig_l1n, busy, l1_err} !== 4'b1100) begin
      fails++; $display("FAIL reset_outputs: got %b want 1100", {trig_l0n, trig_l1n, busy, l1_err});
    end
    tests++;
    if ({l0_cnt, l1_cnt, err_cnt} !== 48'd0) begin
      fails++; $display("FAIL reset_counters: got %h %h %h want 0 0 0", l0_cnt, l1_cnt, err_cnt);
    end
  endtask

  task automatic test_l0;
    int a, b, c, d, e, f, g;
    drive_code(4'b0010);
    measure(14, a, b, c, d, e, f, g);
    tests++;
    if (a !== 10 || b !== 2) begin
      fails++; $display("FAIL l0_pulse: got width %0d start %0d want 10 2", a, b);
    end
    tests++;
    if (g !== 10 || c !== 0) begin
      fails++; $display("FAIL l0_busy: got busy %0d l1low %0d want 10 0", g, c);
    end
    tests++;
    if (l0_cnt !== 16'd1) begin fails++; $display("FAIL l0_cnt: got %0d want 1", l0_cnt); end
  endtask

  task automatic test_l1_window;
    int a, b, c, d, e, f, g;
    drive_code(4'b0010);
    wait_cycles(50);
    drive_l1(1'b0);
    measure(10, a, b, c, d, e, f, g);
    tests++;
    if (c !== 2 || d !== 2) begin
      fails++; $display("FAIL l1_pulse: got width %0d start %0d want 2 2", c, d);
    end
    tests++;
    if (e !== 0 || g !== 3 || a !== 0) begin
      fails++; $display("FAIL l1_side: got err %0d busy %0d l0low %0d want 0 3 0", e, g, a);
    end
    tests++;
    if (l1_cnt !== 16'd1 || l0_cnt !== 16'd2 || err_cnt !== 16'd0) begin
      fails++; $display("FAIL l1_counts: got %0d %0d %0d want 2 1 0", l0_cnt, l1_cnt, err_cnt);
    end
  endtask

  task automatic test_l1_reject;
    int a, b, c, d, e, f, g;
    drive_l1(1'b0);
    measure(10, a, b, c, d, e, f, g);
    tests++;
    if (e !== 1 || f !== 2 || c !== 0) begin
      fails++; $display("FAIL l1_noarm: got err %0d at %0d l1low %0d want 1 2 0", e, f, c);
    end
    tests++;
    if (g !== 7 || busy !== 1'b0 || err_cnt !== 16'd1) begin
      fails++; $display("FAIL l1_noarm_hold: got busy %0d/%b errcnt %0d want 7/0 1", g, busy, err_cnt);
    end
    win_check = 1'b0;
    drive_l1(1'b0);
    measure(10, a, b, c, d, e, f, g);
    win_check = 1'b1;
    tests++;
    if (c !== 2 || e !== 0 || l1_cnt !== 16'd2 || err_cnt !== 16'd1) begin
      fails++; $display("FAIL l1_nocheck: got l1low %0d err %0d l1cnt %0d errcnt %0d want 2 0 2 1",
                        c, e, l1_cnt, err_cnt);
    end
  endtask

  task automatic test_late_and_other;
    int a, b, c, d, e, f, g;
    drive_code(4'b0010);
    wait_cycles(245);
    drive_l1(1'b0);
    measure(10, a, b, c, d, e, f, g);
    tests++;
    if (c !== 0 || e !== 1 || err_cnt !== 16'd2 || l1_cnt !== 16'd2 || l0_cnt !== 16'd3) begin
      fails++; $display("FAIL l1_late: got l1low %0d err %0d cnts %0d %0d %0d want 0 1 3 2 2",
                        c, e, l0_cnt, l1_cnt, err_cnt);
    end
    drive_l1(1'b1);
    measure(10, a, b, c, d, e, f, g);
    dtc_trig = 1'b0;
    tests++;
    if (a !== 0 || c !== 0 || e !== 0 || g !== 7 || busy !== 1'b0) begin
      fails++; $display("FAIL cmd_0111: got l0 %0d l1 %0d err %0d busy %0d/%b want 0 0 0 7/0",
                        a, c, e, g, busy);
    end
    tests++;
    if (err_cnt !== 16'd2 || l1_cnt !== 16'd2) begin
      fails++; $display("FAIL cmd_0111_cnt: got %0d %0d want 2 2", l1_cnt, err_cnt);
    end
  endtask

  task automatic test_ignore_and_disable;
    int a, b, c, d, e, f, g;
    drive_code(4'b0010);
    drive_code(4'b0010);
    measure(15, a, b, c, d, e, f, g);
    tests++;
    if (a !== 7 || l0_cnt !== 16'd4) begin
      fails++; $display("FAIL l0_during_pulse: got low %0d cnt %0d want 7 4", a, l0_cnt);
    end
    en_l0 = 1'b0;
    drive_code(4'b0010);
    measure(14, a, b, c, d, e, f, g);
    en_l0 = 1'b1;
    tests++;
    if (a !== 0 || g !== 0 || l0_cnt !== 16'd4) begin
      fails++; $display("FAIL l0_disabled: got low %0d busy %0d cnt %0d want 0 0 4", a, g, l0_cnt);
    end
  endtask

  task automatic test_reset_mid_pulse;
    drive_code(4'b0010);
    wait_cycles(4);
    tests++;
    if (trig_l0n !== 1'b0 || l0_cnt !== 16'd5) begin
      fails++; $display("FAIL pre_reset: got l0n %b cnt %0d want 0 5", trig_l0n, l0_cnt);
    end
    reset = 1'b1;
    @(negedge clkin);
    tests++;
    if (trig_l0n !== 1'b1 || busy !== 1'b0 || {l0_cnt, l1_cnt, err_cnt} !== 48'd0) begin
      fails++; $display("FAIL mid_reset: got l0n %b busy %b cnts %0d %0d %0d want 1 0 0 0 0",
                        trig_l0n, busy, l0_cnt, l1_cnt, err_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap_clear;
    for (int i = 0; i < 15; i++) begin
      for (int j = 3; j >= 0; j--) begin
        @(negedge clkin);
        dtc_trig_w = (j == 1);
      end
    end
    wait_cycles(2);
    tests++;
    if (w_l0_cnt !== 4'hF) begin fails++; $display("FAIL wrap_pre: got %h want f", w_l0_cnt); end
    for (int j = 3; j >= 0; j--) begin
      @(negedge clkin);
      dtc_trig_w = (j == 1);
    end
    wait_cycles(2);
    tests++;
    if (w_l0_cnt !== 4'h0) begin fails++; $display("FAIL wrap: got %h want 0", w_l0_cnt); end
    drive_code(4'b0010);
    wait_cycles(14);
    tests++;
    if (l0_cnt !== 16'd1) begin fails++; $display("FAIL clr_pre: got %0d want 1", l0_cnt); end
    drive_code(4'b0010);
    @(negedge clkin);
    cnt_clr = 1'b1;
    @(negedge clkin);
    cnt_clr = 1'b0;
    tests++;
    if (l0_cnt !== 16'd0 || trig_l0n !== 1'b0) begin
      fails++; $display("FAIL clr_vs_inc: got cnt %0d l0n %b want 0 0", l0_cnt, trig_l0n);
    end
    wait_cycles(14);
  endtask

  initial begin
    reset = 1'b1; dtc_trig = 1'b0; dtc_trig_w = 1'b0; en_l0 = 1'b1; en_l1 = 1'b1;
    win_check = 1'b1; cnt_clr = 1'b0;
    wait_cycles(3);
    test_reset;
    reset = 1'b0;
    wait_cycles(2);
    test_l0;
    test_l1_window;
    test_l1_reject;
    test_late_and_other;
    test_ignore_and_disable;
    test_reset_mid_pulse;
    test_wrap_clear;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
